// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Issues load/store bus cycles over a
//               req/ack handshake, aligns load data and stalls the pipeline
//               while the bus is busy. LL/SC reservation enabled by LLSC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    input  logic        llbit_clr_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic       c_RSTENABLE  = 1'b1;
    localparam logic       c_NOSTOP     = 1'b0;

    localparam logic [7:0] c_EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] c_EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] c_EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] c_EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] c_EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] c_EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] c_EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] c_EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] c_EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] c_EXE_SC_OP  = 8'b1111_1000;

    localparam logic [1:0] c_SZ_BYTE    = 2'd0;
    localparam logic [1:0] c_SZ_HALF    = 2'd1;
    localparam logic [1:0] c_SZ_WORD    = 2'd2;

    localparam int             c_CW      = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_op;
    logic [31:0]       r_addr;
    logic [31:0]       r_reg2;
    logic [4:0]        r_wd;
    logic              r_wreg_in;
    logic [31:0]       r_wdata_in;
    logic [c_CW-1:0]   r_cnt;
    logic              r_wreg;
    logic [31:0]       r_wdata;
    logic              r_bus_err;

    logic              w_idle;
    logic [7:0]        w_op;
    logic [31:0]       w_addr;
    logic [31:0]       w_reg2;
    logic              w_wreg_cur;
    logic [31:0]       w_wdata_cur;
    logic              w_is_mem;
    logic              w_is_load;
    logic              w_is_signed;
    logic [1:0]        w_size;
    logic              w_is_sc;
    logic              w_is_ll;
    logic              w_misalign;
    logic              w_sc_fail;
    logic              w_start;
    logic              w_active;
    logic [c_CW-1:0]   w_req_cnt;
    logic              w_timeout;
    logic [3:0]        w_sel;
    logic [31:0]       w_bwdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_val;
    logic              w_res_wreg;
    logic [31:0]       w_res_wdata;
    logic              w_unused;

    // The op under service comes straight from EX/MEM in IDLE, from the latch otherwise
    assign w_idle      = (r_state == S_IDLE);
    assign w_op        = w_idle ? aluop_i    : r_op;
    assign w_addr      = w_idle ? mem_addr_i : r_addr;
    assign w_reg2      = w_idle ? reg2_i     : r_reg2;
    assign w_wreg_cur  = w_idle ? wreg_i     : r_wreg_in;
    assign w_wdata_cur = w_idle ? wdata_i    : r_wdata_in;

    always_comb begin
        w_is_mem    = 1'b1;
        w_is_load   = 1'b0;
        w_is_signed = 1'b0;
        w_size      = c_SZ_WORD;
        case (w_op)
            c_EXE_LB_OP:  begin w_is_load = 1'b1; w_is_signed = 1'b1; w_size = c_SZ_BYTE; end
            c_EXE_LBU_OP: begin w_is_load = 1'b1; w_size = c_SZ_BYTE; end
            c_EXE_LH_OP:  begin w_is_load = 1'b1; w_is_signed = 1'b1; w_size = c_SZ_HALF; end
            c_EXE_LHU_OP: begin w_is_load = 1'b1; w_size = c_SZ_HALF; end
            c_EXE_LW_OP,
            c_EXE_LL_OP:  w_is_load = 1'b1;
            c_EXE_SB_OP:  w_size = c_SZ_BYTE;
            c_EXE_SH_OP:  w_size = c_SZ_HALF;
            c_EXE_SW_OP,
            c_EXE_SC_OP:  w_size = c_SZ_WORD;
            default:      w_is_mem = 1'b0;
        endcase
    end

    assign w_is_sc    = (w_op == c_EXE_SC_OP);
    assign w_is_ll    = (w_op == c_EXE_LL_OP);
    assign w_misalign = w_is_mem & (((w_size == c_SZ_HALF) & w_addr[0]) |
                                    ((w_size == c_SZ_WORD) & (w_addr[1:0] != 2'b00)));

`ifdef LLSC_EN
    logic r_llbit;

    // A clear from an exception wins over a reservation set in the same cycle
    always_ff @(posedge clk) begin
        if (rst == c_RSTENABLE) begin
            r_llbit <= 1'b0;
        end else if (llbit_clr_i) begin
            r_llbit <= 1'b0;
        end else if (w_active & bus_ack_i & w_is_ll) begin
            r_llbit <= 1'b1;
        end else if (w_start & w_is_sc) begin
            r_llbit <= 1'b0;
        end
    end

    assign w_sc_fail = w_is_sc & ~r_llbit;
    assign w_unused  = ^{stall_i[5], stall_i[3:0]};
`else
    assign w_sc_fail = 1'b0;
    assign w_unused  = ^{stall_i[5], stall_i[3:0], llbit_clr_i, w_is_ll};
`endif

    assign w_start   = w_idle & w_is_mem & ~w_misalign & ~w_sc_fail;
    assign w_active  = w_start | (r_state == S_WAIT);
    assign w_req_cnt = w_idle ? c_CW'(1) : r_cnt + c_CW'(1);
    assign w_timeout = (TIMEOUT_CYCLES != 0) & w_active & ~bus_ack_i & (w_req_cnt == c_TIMEOUT);

    // Byte lanes are big-endian: address offset 0 maps to bits 31:24
    always_comb begin
        case (w_size)
            c_SZ_BYTE: begin
                w_sel    = 4'b1000 >> w_addr[1:0];
                w_bwdata = {4{w_reg2[7:0]}};
            end
            c_SZ_HALF: begin
                w_sel    = w_addr[1] ? 4'b0011 : 4'b1100;
                w_bwdata = {2{w_reg2[15:0]}};
            end
            default: begin
                w_sel    = 4'b1111;
                w_bwdata = w_reg2;
            end
        endcase
    end

    always_comb begin
        case (w_addr[1:0])
            2'b00:   w_byte = bus_rdata_i[31:24];
            2'b01:   w_byte = bus_rdata_i[23:16];
            2'b10:   w_byte = bus_rdata_i[15:8];
            default: w_byte = bus_rdata_i[7:0];
        endcase
        w_half = w_addr[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        case (w_size)
            c_SZ_BYTE: w_load_val = {{24{w_is_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_val = {{16{w_is_signed & w_half[15]}}, w_half};
            default:   w_load_val = bus_rdata_i;
        endcase
    end

    assign w_res_wreg  = w_is_sc | w_wreg_cur;
    assign w_res_wdata = w_is_load ? w_load_val : (w_is_sc ? 32'd1 : w_wdata_cur);

    always_ff @(posedge clk) begin
        if (rst == c_RSTENABLE) begin
            r_state    <= S_IDLE;
            r_op       <= 8'd0;
            r_addr     <= 32'd0;
            r_reg2     <= 32'd0;
            r_wd       <= 5'd0;
            r_wreg_in  <= 1'b0;
            r_wdata_in <= 32'd0;
            r_cnt      <= '0;
            r_wreg     <= 1'b0;
            r_wdata    <= 32'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_start) begin
                r_op       <= aluop_i;
                r_addr     <= mem_addr_i;
                r_reg2     <= reg2_i;
                r_wd       <= wd_i;
                r_wreg_in  <= wreg_i;
                r_wdata_in <= wdata_i;
            end
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_active) begin
                        r_cnt <= w_req_cnt;
                        if (bus_ack_i) begin
                            r_state <= S_DONE;
                            r_wreg  <= w_res_wreg;
                            r_wdata <= w_res_wdata;
                        end else if (w_timeout) begin
                            r_state   <= S_DONE;
                            r_wreg    <= 1'b0;
                            r_wdata   <= 32'd0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    if (stall_i[4] == c_NOSTOP) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
        case (r_state)
            S_IDLE: begin
                if (w_misalign) begin
                    wreg_o = 1'b0;
                end else if (w_sc_fail) begin
                    wreg_o  = 1'b1;
                    wdata_o = 32'd0;
                end else if (w_start) begin
                    wreg_o = 1'b0;
                end
            end
            S_WAIT: begin
                wd_o    = r_wd;
                wreg_o  = 1'b0;
                wdata_o = 32'd0;
            end
            default: begin
                wd_o    = r_wd;
                wreg_o  = r_wreg;
                wdata_o = r_wdata;
            end
        endcase
    end

    assign hi_o        = hi_i;
    assign lo_o        = lo_i;
    assign whilo_o     = whilo_i;
    assign bus_req_o   = w_active;
    assign stallreq_o  = w_active;
    assign bus_we_o    = w_active & ~w_is_load;
    assign bus_addr_o  = w_active ? {w_addr[31:2], 2'b00} : 32'd0;
    assign bus_sel_o   = w_active ? w_sel : 4'd0;
    assign bus_wdata_o = (w_active & ~w_is_load) ? w_bwdata : 32'd0;
    assign misalign_o  = w_idle & w_misalign;
    assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire
